// File: rtl/mipi_rx_pkg.sv
// Shared types and defaults for the MIPI RX payload path.
package mipi_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } rx_state_t;

    localparam int          MIPI_RX_BEAT_BYTES = 6;
    localparam logic [47:0] MIPI_RX_MARKER     = 48'h7e7e_7e7e_7e7e;

endpackage

// File: rtl/mipi_rx_watchdog.sv
// Inter-beat gap counter: restarts on every qualifying beat, saturates at TIMEOUT,
// and flags expiry on the idle cycle that would bring the gap up to TIMEOUT.
module mipi_rx_watchdog #(
    parameter int TIMEOUT = 4095
) (
    input  logic rx_pixel_clk,
    input  logic rst,
    input  logic restart,
    output logic expired
);
    localparam int            GW      = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT);

    logic [GW-1:0] gap;

    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
        end else if (restart) begin
            gap <= '0;
        end else if (gap != GAP_MAX) begin
            gap <= gap + 1'b1;
        end
    end

    assign expired = !restart && (gap == GAP_MAX - 1'b1);

endmodule

// File: rtl/mipi_rx_payload_assembler.sv
// Hunts for a start marker on one virtual channel and packs the following beats into a
// DLEN-byte payload. Optional trailing XOR checksum beat enabled by MIPI_RX_CHECKSUM_EN.
module mipi_rx_payload_assembler
    import mipi_rx_pkg::*;
#(
    parameter int                      DLEN       = 512,
    parameter int                      BEAT_BYTES = MIPI_RX_BEAT_BYTES,
    parameter logic [BEAT_BYTES*8-1:0] MARKER     = (BEAT_BYTES*8)'(MIPI_RX_MARKER),
    parameter int                      VC_SEL     = 0,
    parameter int                      TIMEOUT    = 4095
) (
    input  logic              rx_pixel_clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rx_valid,
    input  logic [1:0]        rx_vc,
    input  logic [3:0]        rx_vsync,
    input  logic [63:0]       rx_data,
    output logic [DLEN*8-1:0] data,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              busy,
    output logic              frame_err,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic              chk_err
);
    localparam int            CW        = $clog2(DLEN + 8);
    localparam logic [CW-1:0] BEAT_STEP = CW'(BEAT_BYTES);
    localparam logic [CW-1:0] PAY_LEN   = CW'(DLEN);
    localparam logic [1:0]    VC        = 2'(VC_SEL);

    rx_state_t     state;
    logic [CW-1:0] byte_cnt;
    logic          qual;
    logic          is_marker;
    logic          vsync_hit;
    logic          last_beat;
    logic          in_flight;
    logic          expired;
    logic          take_beat;
    logic          unused_inputs;

    assign qual      = rx_valid && (rx_vc == VC);
    assign is_marker = (rx_data[BEAT_BYTES*8-1:0] == MARKER);
    assign vsync_hit = rx_vsync[VC];
    assign last_beat = (byte_cnt + BEAT_STEP) >= PAY_LEN;
    assign in_flight = (state == COLLECT) || (state == CHECK);
    assign take_beat = (state == COLLECT) && qual && !vsync_hit && !clear;
    assign unused_inputs = ^{rx_vsync, rx_data};

    mipi_rx_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .rx_pixel_clk(rx_pixel_clk),
        .rst         (rst),
        .restart     (qual || !in_flight),
        .expired     (expired)
    );

    // Each payload byte has a fixed beat slot and lane; beat bytes past DLEN have no slot.
    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        if (rst) begin
            // NOTE: wide storage is normally left unreset, but this payload drives an output
            // that must read 0 out of reset, so it takes the reset like any control flop.
            data <= '0;
        end else if (take_beat) begin
            for (int k = 0; k < DLEN; k++) begin
                if (byte_cnt == CW'((k / BEAT_BYTES) * BEAT_BYTES)) begin
                    data[8*k +: 8] <= rx_data[8*(k % BEAT_BYTES) +: 8];
                end
            end
        end
    end

`ifdef MIPI_RX_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] beat_xor;

    always_comb begin
        // NOTE: default first, so no path through the loop leaves beat_xor unassigned
        // and no latch is inferred.
        beat_xor = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (byte_cnt + CW'(i) < PAY_LEN) begin
                beat_xor = beat_xor ^ rx_data[8*i +: 8];
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge rx_pixel_clk or posedge rst) begin
        // NOTE: every state register is updated with <= so all of them see the
        // pre-edge values of each other, exactly like the flops they describe.
        if (rst) begin
            state       <= HUNT;
            byte_cnt    <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef MIPI_RX_CHECKSUM_EN
            chk_err     <= 1'b0;
            csum        <= '0;
`endif
        end else if (clear) begin
            state       <= HUNT;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef MIPI_RX_CHECKSUM_EN
            chk_err     <= 1'b0;
`endif
        end else if (in_flight && vsync_hit) begin
            state     <= HUNT;
            busy      <= 1'b0;
            frame_err <= 1'b1;
        end else if (in_flight && expired) begin
            state       <= HUNT;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
        end else begin
            case (state)
                HUNT: begin
                    if (qual && is_marker) begin
                        state    <= COLLECT;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
`ifdef MIPI_RX_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (qual) begin
                        byte_cnt <= byte_cnt + BEAT_STEP;
`ifdef MIPI_RX_CHECKSUM_EN
                        csum     <= csum ^ beat_xor;
                        if (last_beat) begin
                            state <= CHECK;
                        end
`else
                        if (last_beat) begin
                            state      <= HOLD;
                            busy       <= 1'b0;
                            data_valid <= 1'b1;
                        end
`endif
                    end
                end
                CHECK: begin
`ifdef MIPI_RX_CHECKSUM_EN
                    if (qual) begin
                        busy <= 1'b0;
                        if (rx_data[7:0] == csum) begin
                            state      <= HOLD;
                            data_valid <= 1'b1;
                        end else begin
                            state   <= HUNT;
                            chk_err <= 1'b1;
                        end
                    end
`else
                    state <= HUNT;
                    busy  <= 1'b0;
`endif
                end
                HOLD: begin
                    if (qual) begin
                        overrun_err <= 1'b1;
                    end
                    if (data_ack) begin
                        state      <= HUNT;
                        data_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_rx_payload_assembler.sv
// Self-checking bench for mipi_rx_payload_assembler (DLEN=12, BEAT_BYTES=6, TIMEOUT=8).
// Checksum scenarios are exercised when MIPI_RX_CHECKSUM_EN is defined.
module tb_mipi_rx_payload_assembler;
    localparam int          DLEN       = 12;
    localparam int          BEAT_BYTES = 6;
    localparam int          TIMEOUT    = 8;
    localparam logic [47:0] MARK       = 48'h7e7e_7e7e_7e7e;
    localparam logic [47:0] D0         = 48'h0605_0403_0201;
    localparam logic [47:0] D1         = 48'h0C0B_0A09_0807;
    localparam logic [95:0] NOMINAL    = 96'h0C0B0A09_08070605_04030201;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        rx_valid;
    logic [1:0]  rx_vc;
    logic [3:0]  rx_vsync;
    logic [63:0] rx_data;
    logic [95:0] data;
    logic        data_valid;
    logic        data_ack;
    logic        busy;
    logic        frame_err;
    logic        timeout_err;
    logic        overrun_err;
    logic        chk_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mipi_rx_payload_assembler #(
        .DLEN      (DLEN),
        .BEAT_BYTES(BEAT_BYTES),
        .MARKER    (MARK),
        .VC_SEL    (0),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .rx_pixel_clk(clk),
        .rst         (rst),
        .clear       (clear),
        .rx_valid    (rx_valid),
        .rx_vc       (rx_vc),
        .rx_vsync    (rx_vsync),
        .rx_data     (rx_data),
        .data        (data),
        .data_valid  (data_valid),
        .data_ack    (data_ack),
        .busy        (busy),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .chk_err     (chk_err)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  vc;
        logic [63:0] rdata;
        logic        exp_busy;
    } hunt_vec_t;

    hunt_vec_t vecs[7];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 96'(act), 96'(exp));
    endtask

    function automatic logic [3:0] errs();
        return {frame_err, timeout_err, overrun_err, chk_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0;
        rx_vc    = 2'd0;
        rx_vsync = 4'd0;
        rx_data  = 64'd0;
    endtask

    task automatic idle(input int n);
        idle_inputs();
        repeat (n) tick();
    endtask

    task automatic beat(input logic [1:0] vc, input logic [47:0] d, input logic [3:0] vs);
        rx_valid = 1'b1;
        rx_vc    = vc;
        rx_vsync = vs;
        rx_data  = {16'($urandom), d};
        tick();
        idle_inputs();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    // Non-qualifying cycles: idle, or valid on another VC; VSYNC only on other VCs.
    task automatic junk(input int n);
        repeat (n) begin
            rx_valid = 1'($urandom);
            rx_vc    = rx_valid ? 2'($urandom_range(1, 3)) : 2'($urandom);
            rx_data  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rx_data[47:0] = MARK;
            rx_vsync = {3'($urandom), 1'b0};
            tick();
        end
        idle_inputs();
    endtask

    function automatic logic [7:0] payload_xor(input logic [95:0] p);
        logic [7:0] x = 8'd0;
        for (int k = 0; k < DLEN; k++) x ^= p[8*k +: 8];
        return x;
    endfunction

    // Marker, two payload beats and (when enabled) a checksum beat with the given byte 0.
    task automatic send_frame(input logic [7:0] ck);
        beat(2'd0, MARK, 4'd0);
        beat(2'd0, D0, 4'd0);
        beat(2'd0, D1, 4'd0);
`ifdef MIPI_RX_CHECKSUM_EN
        beat(2'd0, {40'h0, ck}, 4'd0);
`else
        if (ck == 8'hFF) idle(0);
`endif
    endtask

    logic [7:0]  q[$];
    logic [47:0] d;
    logic [95:0] exp_data;
    logic [7:0]  exp_x;

    initial begin
        vecs[0] = '{1'b1, 2'd0, {16'h0000, MARK}, 1'b1};
        vecs[1] = '{1'b1, 2'd1, {16'h0000, MARK}, 1'b0};
        vecs[2] = '{1'b0, 2'd0, {16'h0000, MARK}, 1'b0};
        vecs[3] = '{1'b1, 2'd0, {16'h0000, MARK ^ 48'h1}, 1'b0};
        vecs[4] = '{1'b1, 2'd3, {16'h0000, MARK}, 1'b0};
        vecs[5] = '{1'b1, 2'd0, {16'hDEAD, MARK}, 1'b1};
        vecs[6] = '{1'b1, 2'd0, {16'h0000, MARK ^ 48'h8000_0000_0000}, 1'b0};

        clear    = 1'b0;
        data_ack = 1'b0;
        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset data", data, 96'd0);
        check1("reset data_valid", data_valid, 1'b0);
        check1("reset busy", busy, 1'b0);
        check("reset errors", 96'(errs()), 96'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Marker qualification in HUNT
        for (int i = 0; i < 7; i++) begin
            pulse_clear();
            check1($sformatf("hunt[%0d] busy after clear", i), busy, 1'b0);
            rx_valid = vecs[i].valid;
            rx_vc    = vecs[i].vc;
            rx_data  = vecs[i].rdata;
            tick();
            idle_inputs();
            check1($sformatf("hunt[%0d] busy", i), busy, vecs[i].exp_busy);
        end
        pulse_clear();

        // Nominal frame; VSYNC on another VC must be ignored
        beat(2'd0, MARK, 4'd0);
        check1("nominal busy after marker", busy, 1'b1);
        beat(2'd0, D0, 4'b0010);
        check1("nominal valid mid-frame", data_valid, 1'b0);
        beat(2'd0, D1, 4'd0);
`ifdef MIPI_RX_CHECKSUM_EN
        check1("nominal valid before checksum", data_valid, 1'b0);
        check1("nominal busy in check", busy, 1'b1);
        beat(2'd0, 48'h0000_0000_000C, 4'd0);
`endif
        check1("nominal data_valid", data_valid, 1'b1);
        check1("nominal busy in hold", busy, 1'b0);
        check("nominal data", data, NOMINAL);
        idle(2);
        check1("nominal valid held", data_valid, 1'b1);
        ack();
        check1("nominal valid after ack", data_valid, 1'b0);

        // VSYNC abort, then a stray beat must not complete anything
        beat(2'd0, MARK, 4'd0);
        beat(2'd0, D0, 4'd0);
        rx_vsync = 4'b0001;
        tick();
        idle_inputs();
        check1("vsync frame_err", frame_err, 1'b1);
        check1("vsync busy", busy, 1'b0);
        check1("vsync data_valid", data_valid, 1'b0);
        beat(2'd0, D1, 4'd0);
        idle(2);
        check1("vsync no late valid", data_valid, 1'b0);
        pulse_clear();
        check("vsync errors cleared", 96'(errs()), 96'd0);

        // VSYNC beats a payload beat in the same cycle
        beat(2'd0, MARK, 4'd0);
        beat(2'd0, D0, 4'd0);
        beat(2'd0, D1, 4'b0001);
        idle(2);
        check1("vsync+beat frame_err", frame_err, 1'b1);
        check1("vsync+beat data_valid", data_valid, 1'b0);
        pulse_clear();

        // Timeout: 7 idle cycles survive, the 8th aborts
        beat(2'd0, MARK, 4'd0);
        beat(2'd0, D0, 4'd0);
        idle(TIMEOUT - 1);
        check1("timeout not yet", timeout_err, 1'b0);
        check1("timeout busy still", busy, 1'b1);
        idle(1);
        check1("timeout_err", timeout_err, 1'b1);
        check1("timeout busy", busy, 1'b0);
        pulse_clear();
        check1("timeout cleared", timeout_err, 1'b0);

        // A beat arriving just before expiry keeps the frame alive
        beat(2'd0, MARK, 4'd0);
        beat(2'd0, D0, 4'd0);
        idle(TIMEOUT - 1);
        beat(2'd0, D1, 4'd0);
`ifdef MIPI_RX_CHECKSUM_EN
        idle(TIMEOUT - 1);
        beat(2'd0, 48'h0000_0000_000C, 4'd0);
`endif
        check1("late beat data_valid", data_valid, 1'b1);
        check1("late beat timeout_err", timeout_err, 1'b0);
        ack();

        // Overrun during HOLD, then ack with a simultaneous marker, then clear
        send_frame(8'h0C);
        beat(2'd0, 48'h1111_1111_1111, 4'd0);
        check1("overrun_err", overrun_err, 1'b1);
        check("overrun data frozen", data, NOMINAL);
        check1("overrun valid held", data_valid, 1'b1);
        data_ack = 1'b1;
        rx_valid = 1'b1;
        rx_data  = {16'h0, MARK};
        tick();
        data_ack = 1'b0;
        idle_inputs();
        check1("ack+marker valid", data_valid, 1'b0);
        check1("ack+marker busy", busy, 1'b0);
        pulse_clear();
        check("clear errors", 96'(errs()), 96'd0);
        check1("clear data_valid", data_valid, 1'b0);

        // Clear drops data_valid straight out of HOLD
        send_frame(8'h0C);
        check1("pre-clear valid", data_valid, 1'b1);
        pulse_clear();
        check1("clear from hold", data_valid, 1'b0);

`ifdef MIPI_RX_CHECKSUM_EN
        send_frame(8'h00);
        check1("bad checksum chk_err", chk_err, 1'b1);
        check1("bad checksum data_valid", data_valid, 1'b0);
        check1("bad checksum busy", busy, 1'b0);
        pulse_clear();
        check1("chk_err cleared", chk_err, 1'b0);
`else
        send_frame(8'h00);
        check1("chk_err tied low", chk_err, 1'b0);
        ack();
`endif

        // Asynchronous reset mid-frame
        beat(2'd0, MARK, 4'd0);
        beat(2'd0, D0, 4'd0);
        #2 rst = 1'b1;
        #1;
        check1("async reset busy", busy, 1'b0);
        check("async reset data", data, 96'd0);
        #2 rst = 1'b0;
        tick();
        beat(2'd0, D1, 4'd0);
        idle(2);
        check1("after reset no valid", data_valid, 1'b0);

        // Randomized frames against a byte-queue reference model
        for (int f = 0; f < 25; f++) begin
            q.delete();
            junk($urandom_range(0, 3));
            beat(2'd0, MARK, {3'($urandom), 1'b0});
            while (q.size() < DLEN) begin
                junk($urandom_range(0, 3));
                d = {16'($urandom), 32'($urandom)};
                if ($urandom_range(0, 5) == 0) d = MARK;
                beat(2'd0, d, {3'($urandom), 1'b0});
                for (int i = 0; i < BEAT_BYTES; i++) q.push_back(d[8*i +: 8]);
            end
            exp_data = '0;
            for (int k = 0; k < DLEN; k++) exp_data[8*k +: 8] = q[k];
            exp_x = payload_xor(exp_data);
`ifdef MIPI_RX_CHECKSUM_EN
            junk($urandom_range(0, 3));
            beat(2'd0, {40'($urandom), exp_x}, 4'd0);
`else
            if (exp_x == 8'h00) idle(0);
`endif
            check1($sformatf("rand[%0d] data_valid", f), data_valid, 1'b1);
            check($sformatf("rand[%0d] data", f), data, exp_data);
            junk($urandom_range(0, 2));
            check($sformatf("rand[%0d] data held", f), data, exp_data);
            check($sformatf("rand[%0d] errors", f), 96'(errs()), 96'd0);
            ack();
            check1($sformatf("rand[%0d] ack", f), data_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
